// File: rtl/alu_acc_8bit.sv
// alu_acc_8bit: sequencing and result stage around the external full_adder_8bit.
// A command is accepted over InValid/InReady. For one EXEC cycle the block drives
// the adder from registers, then captures Sum/Cout into the accumulator and the
// {N,Z,C,V} flags. The result is held over OutValid/OutReady until it is taken.
// Optional build macro: ALU_ACC_SAT_EN selects unsigned saturation of the result.
// When it is undefined, results wrap modulo 256.
module alu_acc_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       InValid,
    output logic       InReady,
    input  logic [1:0] Op,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] AddA,
    output logic [7:0] AddB,
    output logic       AddCin,
    input  logic [7:0] AddSum,
    input  logic       AddCout,
    output logic       OutValid,
    input  logic       OutReady,
    output logic [7:0] Result,
    output logic [3:0] Flags
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    // Flag value after reset and after CLR: only Z set.
    localparam logic [3:0] FLAGS_CLEAR = 4'b0100;

    // Signed overflow of an addition: operands agree in sign, sum disagrees.
    function automatic logic calc_overflow(input logic a_msb, input logic b_msb,
                                           input logic sum_msb);
        calc_overflow = (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

    logic [1:0] state_r;
    logic [1:0] op_r;
    logic [7:0] add_a_r;
    logic [7:0] add_b_r;
    logic       add_cin_r;
    logic [7:0] acc_r;
    logic [3:0] flags_r;
    logic       in_ready_r;
    logic       out_valid_r;

    logic [7:0] drive_a_s;
    logic [7:0] drive_b_s;
    logic       drive_cin_s;
    logic [7:0] res_s;
    logic       carry_s;
    logic       ovf_s;
    logic [3:0] flags_s;

    assign InReady  = in_ready_r;
    assign OutValid = out_valid_r;
    assign AddA     = add_a_r;
    assign AddB     = add_b_r;
    assign AddCin   = add_cin_r;
    assign Result   = acc_r;
    assign Flags    = flags_r;

    // Adder drive for the incoming command; it is loaded into registers on acceptance.
    always_comb begin
        drive_a_s   = 8'h00;
        drive_b_s   = 8'h00;
        drive_cin_s = 1'b0;
        case (Op)
            OP_ADD: begin
                drive_a_s   = A;
                drive_b_s   = B;
                drive_cin_s = 1'b0;
            end
            OP_SUB: begin
                drive_a_s   = A;
                drive_b_s   = ~B;
                drive_cin_s = 1'b1;
            end
            OP_ACC: begin
                drive_a_s   = acc_r;
                drive_b_s   = A;
                drive_cin_s = 1'b0;
            end
            default: begin
                // CLR does not use the adder, so it is parked at zero.
                drive_a_s   = 8'h00;
                drive_b_s   = 8'h00;
                drive_cin_s = 1'b0;
            end
        endcase
    end

    // Result and flags from the adder's output during EXEC.
    always_comb begin
        res_s   = AddSum;
        carry_s = AddCout;
        ovf_s   = calc_overflow(add_a_r[7], add_b_r[7], AddSum[7]);
        case (op_r)
            OP_ADD, OP_ACC: begin
`ifdef ALU_ACC_SAT_EN
                if (AddCout) begin
                    res_s = 8'hFF;
                end else begin
                    res_s = AddSum;
                end
`else
                res_s = AddSum;
`endif
            end
            OP_SUB: begin
`ifdef ALU_ACC_SAT_EN
                if (!AddCout) begin
                    res_s = 8'h00;
                end else begin
                    res_s = AddSum;
                end
`else
                res_s = AddSum;
`endif
            end
            default: begin
                // CLR: zero result, and C and V are cleared.
                res_s   = 8'h00;
                carry_s = 1'b0;
                ovf_s   = 1'b0;
            end
        endcase
        flags_s = {res_s[7], (res_s == 8'h00), carry_s, ovf_s};
    end

    // Control FSM, operand/drive registers, accumulator and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_ADD;
            add_a_r     <= 8'h00;
            add_b_r     <= 8'h00;
            add_cin_r   <= 1'b0;
            acc_r       <= 8'h00;
            flags_r     <= FLAGS_CLEAR;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (InValid && in_ready_r) begin
                        op_r       <= Op;
                        add_a_r    <= drive_a_s;
                        add_b_r    <= drive_b_s;
                        add_cin_r  <= drive_cin_s;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_EXEC;
                    end else begin
                        in_ready_r <= 1'b1;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    acc_r       <= res_s;
                    flags_r     <= flags_s;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (OutReady) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc_8bit.sv
// Directed testbench for alu_acc_8bit. A behavioural stand-in for full_adder_8bit
// is wired to the adder ports. Expectations are hand-computed constants, plus a
// small A+B reference for the ADD sweep. They follow ALU_ACC_SAT_EN if it is defined.
module tb_alu_acc_8bit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic [7:0] add_sum;
    logic       add_cout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] flags;

    int n_pass;
    int n_fail;
    int n_total;

    alu_acc_8bit dut (
        .clk      (clk),
        .rst      (rst),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .Op       (op),
        .A        (a),
        .B        (b),
        .AddA     (add_a),
        .AddB     (add_b),
        .AddCin   (add_cin),
        .AddSum   (add_sum),
        .AddCout  (add_cout),
        .OutValid (out_valid),
        .OutReady (out_ready),
        .Result   (result),
        .Flags    (flags)
    );

    // Stand-in for the external full_adder_8bit.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command. Return in DONE, before the result handshake.
    task automatic do_op(input logic [1:0] o, input logic [7:0] va, input logic [7:0] vb,
                         input bit chk_drv, input logic [7:0] ea, input logic [7:0] eb,
                         input logic ecin);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op = o;
        a = va;
        b = vb;
        step();
        in_valid = 1'b0;
        chk("exec_out_valid", {31'd0, out_valid}, 32'd0);
        chk("exec_in_ready", {31'd0, in_ready}, 32'd0);
        if (chk_drv) begin
            chk("exec_add_a", {24'd0, add_a}, {24'd0, ea});
            chk("exec_add_b", {24'd0, add_b}, {24'd0, eb});
            chk("exec_add_cin", {31'd0, add_cin}, {31'd0, ecin});
        end
        step();
        chk("done_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic chk_res(input string tag, input logic [7:0] er, input logic [3:0] ef);
        chk({tag, "_result"}, {24'd0, result}, {24'd0, er});
        chk({tag, "_flags"}, {28'd0, flags}, {28'd0, ef});
    endtask

    initial begin
        logic [8:0] sum9;
        logic [7:0] er;
        logic [3:0] ef;
        logic [7:0] sa;
        logic [7:0] sb;
        n_pass = 0;
        n_fail = 0;
        n_total = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        op = 2'b00;
        a = 8'h00;
        b = 8'h00;
        out_ready = 1'b0;

        // Reset held for two edges.
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk_res("rst", 8'h00, 4'b0100);
        chk("rst_add_a", {24'd0, add_a}, 32'd0);
        chk("rst_add_b", {24'd0, add_b}, 32'd0);
        chk("rst_add_cin", {31'd0, add_cin}, 32'd0);

        // ADD 0x7F+0x01: signed overflow into the sign bit.
        do_op(2'b00, 8'h7F, 8'h01, 1'b1, 8'h7F, 8'h01, 1'b0);
        chk_res("add_7f_01", 8'h80, 4'b1001);
        handshake();

        // SUB 0x05-0x05: zero, no borrow.
        do_op(2'b01, 8'h05, 8'h05, 1'b1, 8'h05, 8'hFA, 1'b1);
        chk_res("sub_05_05", 8'h00, 4'b0110);
        handshake();

        // SUB 0x03-0x05: borrow.
        do_op(2'b01, 8'h03, 8'h05, 1'b1, 8'h03, 8'hFA, 1'b1);
`ifdef ALU_ACC_SAT_EN
        chk_res("sub_03_05", 8'h00, 4'b0100);
`else
        chk_res("sub_03_05", 8'hFE, 4'b1000);
`endif
        handshake();

        // ADD 0x80+0x80: carry out and signed overflow.
        do_op(2'b00, 8'h80, 8'h80, 1'b1, 8'h80, 8'h80, 1'b0);
`ifdef ALU_ACC_SAT_EN
        chk_res("add_80_80", 8'hFF, 4'b1011);
`else
        chk_res("add_80_80", 8'h00, 4'b0111);
`endif
        handshake();

        // SUB 0x80-0x01: signed overflow, no borrow.
        do_op(2'b01, 8'h80, 8'h01, 1'b1, 8'h80, 8'hFE, 1'b1);
        chk_res("sub_80_01", 8'h7F, 4'b0011);
        handshake();

        // CLR, then ACC starts from zero.
        do_op(2'b11, 8'h5A, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0);
        chk_res("clr", 8'h00, 4'b0100);
        handshake();
        do_op(2'b10, 8'h33, 8'h99, 1'b1, 8'h00, 8'h33, 1'b0);
        chk_res("acc_after_clr", 8'h33, 4'b0000);
        handshake();

        // ADD 0xF0+0x20 with a 5-cycle output stall and ignored InValid pulses.
        do_op(2'b00, 8'hF0, 8'h20, 1'b1, 8'hF0, 8'h20, 1'b0);
`ifdef ALU_ACC_SAT_EN
        er = 8'hFF;
        ef = 4'b1010;
`else
        er = 8'h10;
        ef = 4'b0010;
`endif
        chk_res("add_f0_20", er, ef);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            op = 2'b11;
            a = 8'h77;
            step();
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk_res("stall", er, ef);
        end
        in_valid = 1'b0;
        handshake();
        chk_res("after_stall_hold", er, ef);
`ifdef ALU_ACC_SAT_EN
        do_op(2'b10, 8'h10, 8'h00, 1'b1, 8'hFF, 8'h10, 1'b0);
        chk_res("acc_10", 8'hFF, 4'b1010);
`else
        do_op(2'b10, 8'h10, 8'h00, 1'b1, 8'h10, 8'h10, 1'b0);
        chk_res("acc_10", 8'h20, 4'b0000);
`endif
        handshake();

        // ADD sweep over a spread of operand pairs against an A+B reference.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                sa = 8'(i * 17);
                sb = 8'(j * 15 + 3);
                sum9 = {1'b0, sa} + {1'b0, sb};
`ifdef ALU_ACC_SAT_EN
                er = sum9[8] ? 8'hFF : sum9[7:0];
`else
                er = sum9[7:0];
`endif
                ef = {er[7], (er == 8'h00), sum9[8],
                      (sa[7] == sb[7]) && (sum9[7] != sa[7])};
                do_op(2'b00, sa, sb, 1'b1, sa, sb, 1'b0);
                chk_res("sweep", er, ef);
                handshake();
            end
        end

        // Reset during EXEC discards the transaction and clears the accumulator.
        do_op(2'b00, 8'h01, 8'h01, 1'b1, 8'h01, 8'h01, 1'b0);
        handshake();
        in_valid = 1'b1;
        op = 2'b00;
        a = 8'h12;
        b = 8'h34;
        step();
        in_valid = 1'b0;
        chk("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk_res("mid_rst", 8'h00, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        do_op(2'b00, 8'h01, 8'h02, 1'b1, 8'h01, 8'h02, 1'b0);
        chk_res("after_rst", 8'h03, 4'b0000);
        handshake();

        // Reset together with InValid in IDLE: the command is not accepted.
        in_valid = 1'b1;
        rst = 1'b1;
        step();
        in_valid = 1'b0;
        rst = 1'b0;
        chk("rst_vs_valid_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("rst_vs_valid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_vs_valid_idle", {31'd0, in_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
